// File: rtl/interconnect_pkg.sv
// Shared link-level types and sizing for the inter-PE channel network.
package interconnect_pkg;

    localparam int TIA_CHANNEL_BUFFER_FIFO_DEPTH = 4;
    localparam int TIA_TAG_WIDTH                 = 3;
    localparam int TIA_WORD_WIDTH                = 32;

    typedef struct packed {
        logic [TIA_TAG_WIDTH-1:0]  tag;
        logic [TIA_WORD_WIDTH-1:0] data;
    } packet_t;

endpackage

// File: rtl/interconnect_if.sv
// Link (sender -> receiver handshake) and PE input-channel interfaces.
interface link_if;
    import interconnect_pkg::*;

    logic    req;
    packet_t packet;
    logic    ack;

    modport sender   (output req, output packet, input ack);
    modport receiver (input req, input packet, output ack);
endinterface

interface input_channel_if #(
    parameter int FIFO_DEPTH = interconnect_pkg::TIA_CHANNEL_BUFFER_FIFO_DEPTH
);
    import interconnect_pkg::*;

    packet_t                     packet;
    logic                        empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        dequeue;

    modport sender   (output packet, output empty, output count, input dequeue);
    modport receiver (input packet, input empty, input count, output dequeue);
endinterface

// File: rtl/input_channel_buffer.sv
// Receive-side FIFO of a PE-to-PE link: acks packets from the link and presents
// the oldest one to the PE trigger logic as an input channel.
module input_channel_buffer
    import interconnect_pkg::*;
#(
    parameter int FIFO_DEPTH = TIA_CHANNEL_BUFFER_FIFO_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    link_if.receiver                link,
    input_channel_if.sender         input_channel,
    output logic                    quiescent
);

    localparam int              PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    packet_t          fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             deq_ok;
    logic             accept;

    assign deq_ok = !reset && enable && input_channel.dequeue && (count != '0);

    // A full buffer may still accept when the PE frees a slot in the same cycle.
    assign link.ack = !reset && enable && link.req && ((count != FULL_COUNT) || deq_ok);
    assign accept   = link.req && link.ack;

    assign input_channel.packet = fifo[head];
    assign input_channel.empty  = (count == '0);
    assign input_channel.count  = count;
    assign quiescent            = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (enable) begin
            if (accept) tail <= tail + PTR_W'(1);
            if (deq_ok) head <= head + PTR_W'(1);
            if (accept && !deq_ok)
                count <= count + (PTR_W + 1)'(1);
            else if (!accept && deq_ok)
                count <= count - (PTR_W + 1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; empty/count gate its visibility,
    // and leaving it reset-free lets it map onto plain RAM/flop arrays.
    always_ff @(posedge clock) begin
        if (accept) fifo[tail] <= link.packet;
    end

    count_bound: assert property (@(posedge clock) count <= FULL_COUNT);

    dequeue_empty: assert property (@(posedge clock) disable iff (reset)
        !(enable && input_channel.dequeue && count == '0))
        else $warning("input_channel_buffer: dequeue while empty ignored");

    packet_stable: assert property (@(posedge clock) disable iff (reset)
        (link.req && !link.ack) |=> (!link.req || $stable(link.packet)));

endmodule

// File: tb/tb_input_channel_buffer.sv
// Directed bench for input_channel_buffer with FIFO_DEPTH=4 and hand-computed expectations.
module tb_input_channel_buffer;
    import interconnect_pkg::*;

    logic clock;
    logic reset;
    logic enable;
    logic quiescent;
    int   checks = 0;
    int   errors = 0;

    link_if                          link ();
    input_channel_if #(.FIFO_DEPTH(4)) ich ();

    input_channel_buffer #(.FIFO_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .link          (link),
        .input_channel (ich),
        .quiescent     (quiescent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one edge and settle; inputs change only here, away from the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] d);
        link.packet.data = d;
        link.packet.tag  = d[2:0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] drain_exp [4];
        drain_exp = '{32'h22, 32'h33, 32'h44, 32'h55};

        reset       = 1'b1;
        enable      = 1'b1;
        link.req    = 1'b1;
        ich.dequeue = 1'b0;
        offer(32'hAA);

        // Reset held for two edges with a pending offer.
        #1 check("reset_ack0", link.ack, 0);
        cyc();
        check("reset_ack1", link.ack, 0);
        cyc();
        check("reset_ack2", link.ack, 0);
        reset    = 1'b0;
        link.req = 1'b0;
        #1;
        check("idle_empty", ich.empty, 1);
        check("idle_count", ich.count, 0);
        check("idle_quiescent", quiescent, 1);

        // Fill to full with no dequeue.
        link.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'h11 * (i + 1));
            #1 check("fill_ack", link.ack, 1);
            cyc();
            check("fill_count", ich.count, i + 1);
        end
        offer(32'h55);
        #1;
        check("full_ack", link.ack, 0);
        check("full_head", ich.packet.data, 32'h11);
        check("full_empty", ich.empty, 0);
        check("full_quiescent", quiescent, 0);
        cyc();
        check("full_hold_count", ich.count, 4);
        check("full_hold_ack", link.ack, 0);

        // Full pass-through: dequeue frees a slot the same cycle.
        ich.dequeue = 1'b1;
        #1 check("pass_ack", link.ack, 1);
        cyc();
        check("pass_count", ich.count, 4);
        check("pass_head", ich.packet.data, 32'h22);
        link.req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("drain_order", ich.packet.data, drain_exp[k]);
            cyc();
        end
        ich.dequeue = 1'b0;
        check("drain_count", ich.count, 0);
        check("drain_empty", ich.empty, 1);

        // Streaming: one in, one out per cycle across several pointer wraps.
        link.req = 1'b1;
        offer(32'h100);
        #1 check("stream_first_ack", link.ack, 1);
        cyc();
        check("stream_first_count", ich.count, 1);
        ich.dequeue = 1'b1;
        for (int i = 1; i < 20; i++) begin
            offer(32'h100 + i);
            #1;
            check("stream_ack", link.ack, 1);
            check("stream_order", ich.packet.data, 32'h100 + i - 1);
            cyc();
            check("stream_count", ich.count, 1);
        end
        link.req = 1'b0;
        #1 check("stream_last", ich.packet.data, 32'h113);
        cyc();
        ich.dequeue = 1'b0;
        check("stream_end_count", ich.count, 0);

        // Dequeue while empty: head stays on slot 1, which last held 0x110.
        check("empty_head_before", ich.packet.data, 32'h110);
        ich.dequeue = 1'b1;
        cyc();
        ich.dequeue = 1'b0;
        check("empty_deq_count", ich.count, 0);
        check("empty_deq_head", ich.packet.data, 32'h110);

        // Enable low freezes everything, even with req and a non-empty buffer.
        link.req = 1'b1;
        offer(32'h66);
        cyc();
        check("pre_enable_count", ich.count, 1);
        offer(32'h77);
        ich.dequeue = 1'b1;
        enable      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("disabled_ack", link.ack, 0);
            cyc();
            check("disabled_count", ich.count, 1);
            check("disabled_head", ich.packet.data, 32'h66);
        end
        enable = 1'b1;
        #1 check("reenable_ack", link.ack, 1);
        cyc();
        ich.dequeue = 1'b0;
        check("reenable_count", ich.count, 1);
        check("reenable_head", ich.packet.data, 32'h77);

        // Bring count to 3, then reset mid-operation with req and dequeue active.
        offer(32'h88);
        cyc();
        offer(32'h99);
        cyc();
        check("pre_reset_count", ich.count, 3);
        reset       = 1'b1;
        ich.dequeue = 1'b1;
        offer(32'hAB);
        #1 check("midreset_ack", link.ack, 0);
        cyc();
        reset       = 1'b0;
        link.req    = 1'b0;
        ich.dequeue = 1'b0;
        #1;
        check("midreset_count", ich.count, 0);
        check("midreset_empty", ich.empty, 1);
        check("midreset_quiescent", quiescent, 1);
        link.req = 1'b1;
        offer(32'hCD);
        #1 check("post_reset_ack", link.ack, 1);
        cyc();
        link.req = 1'b0;
        check("post_reset_count", ich.count, 1);
        check("post_reset_slot0", ich.packet.data, 32'hCD);
        check("post_reset_tag", ich.packet.tag, 3'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_channel_buffer.md
Name: input_channel_buffer

Overview:
- Receiving end of a point-to-point link between processing elements, one instance per input channel.
- Accepts packets offered on a link (req/packet, ack back to the sender) and holds them in a FIFO.
- Presents the oldest packet to the PE trigger logic as an input channel with empty/count status and a dequeue strobe.
- Counterpart of the output channel buffer on the far end of the same link; together they make a two-stage elastic channel.

Parameters:
- FIFO_DEPTH, default TIA_CHANNEL_BUFFER_FIFO_DEPTH. Number of packet entries. Must be a power of two and at least 2.

Ports:
- clock  input  1  positive-edge clock.
- reset  input  1  synchronous, active-high.
- enable  input  1  active-high. Freezes all state updates when low.
- link  link_if.receiver  -  req (in, 1), packet (in, packet_t), ack (out, 1).
- input_channel  input_channel_if.sender  -  packet (out, packet_t), empty (out, 1), count (out, $clog2(FIFO_DEPTH)+1), dequeue (in, 1).
- quiescent  output  1  high when the FIFO holds no packets.

Behaviour:
- State:
  - fifo[FIFO_DEPTH] of packet_t.
  - head and tail, each $clog2(FIFO_DEPTH) bits, wrapping naturally modulo FIFO_DEPTH.
  - count, $clog2(FIFO_DEPTH)+1 bits.
- Reset (synchronous, sampled at posedge):
  - head, tail and count go to 0.
  - FIFO contents are not cleared.
  - Reset overrides enable and any in-flight req/dequeue; a packet offered in the reset cycle is not acked and not stored.
- Combinational outputs:
  - input_channel.packet = fifo[head].
  - empty = (count == 0).
  - input_channel.count = count.
  - quiescent = (count == 0).
- Effective dequeue: deq_ok = enable && dequeue && (count != 0). A dequeue while empty is ignored.
- Ack: ack = enable && req && ((count != FIFO_DEPTH) || deq_ok).
  - A full buffer may accept in the same cycle the PE frees a slot.
  - ack is purely combinational from req, dequeue and state. ack must not depend on ack from the sender side, so there is no loop.
- Transfer: a packet moves on any cycle with req && ack. A sender that sees ack low must hold req and packet stable.
- Sequential update at posedge, when enable is high and reset is low:
  - Accept only: fifo[tail] <= link.packet, tail+1, count+1.
  - Dequeue only: head+1, count-1.
  - Accept and dequeue together: write fifo[tail], tail+1, head+1, count unchanged.
  - Accept and dequeue with count==0 cannot occur, because deq_ok requires count != 0.
  - Neither: hold.
- Latency: a packet accepted at edge N is visible on input_channel.packet, with empty low, after edge N. There is no same-cycle bypass to the PE.
- Throughput: one accept and one dequeue per cycle, sustained at any occupancy.
- enable low: ack forced low, dequeue ignored, all state held. Outputs still reflect the stored state.
- Wrap-around: head and tail wrap from FIFO_DEPTH-1 to 0 with no special case, since FIFO_DEPTH is a power of two.
- Assertions (simulation only):
  - count <= FIFO_DEPTH.
  - Warning on dequeue while empty.
  - link.packet stable while req is high and ack is low.

Decomposition:
- interconnect package / interconnect.svh holds:
  - packet_t (tag + data).
  - TIA_CHANNEL_BUFFER_FIFO_DEPTH.
  - the link_if and input_channel_if interface definitions with their modports.
- The block is self-contained with no sub-module. Pointer/count logic is inline, about 120 lines.

Test Plan:
- Reset and idle: assert reset for 2 cycles with req=1 → ack=0 throughout, then empty=1, count=0, quiescent=1.
- Fill to full (FIFO_DEPTH=4): offer packets with data 0x11..0x55 and no dequeue.
  - The first four are acked on consecutive cycles; count goes 1,2,3,4.
  - 0x55 sees ack=0 and is held.
  - input_channel.packet = 0x11.
- Full pass-through: while count=4 with 0x55 pending, pulse dequeue.
  - ack=1 that cycle; count stays 4.
  - Head becomes 0x22; 0x55 is later dequeued fifth, confirming order.
- Streaming wrap: 20 packets with req and dequeue held high after the first accept.
  - count stays 1.
  - Output order exactly matches input order across 5 pointer wraps.
- Empty dequeue and enable: dequeue with count=0 → count stays 0, no pointer change. With enable=0, req=1 and dequeue=1 → ack=0 and state frozen for 3 cycles.
- Mid-operation reset: with count=3, assert reset with req=1 and dequeue=1 → after the edge count=0, empty=1, the offered packet is not acked, and a subsequent accept lands at index 0.
